ps2_frame_receiver: RTL

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_frame_receiver.sv
// ---------------------------------------------------------------------------
// ps2_frame_receiver
//
// Receives 11-bit PS/2 device-to-host frames: start bit 0, eight data bits
// sent LSB first, odd parity, stop bit 1. The raw PS/2 lines are
// synchronized and the clock is glitch-filtered. Each bit is sampled on a
// falling edge of the filtered clock. If the clock stays quiet for too long
// in the middle of a frame, the partial frame is dropped.
//
// Optional feature macro: PS2_PARITY_CHECK_EN
//   defined   - a frame that fails parity but has a valid stop bit pulses
//               parity_error. It is not delivered.
//   undefined - the parity bit is consumed and ignored. parity_error is
//               tied to 0.
//
// Parameters
//   FILTER_LEN         consecutive equal synchronized PS2_CLK samples needed
//                      before the filtered clock takes a new level
//   TIMEOUT_CYCLES     idle CLOCK_50 cycles allowed between falling edges
//                      while a frame is in progress
//
// Ports
//   CLOCK_50           system clock; all logic runs on its rising edge
//   reset              synchronous, active-high reset
//   PS2_CLK            raw PS/2 clock (asynchronous)
//   PS2_DAT            raw PS/2 data (asynchronous)
//   last_data_received byte from the last good frame, held until the next one
//   key_pressed        one-cycle strobe per good frame
//   frame_error        one-cycle strobe for a bad stop bit or a timeout
//   parity_error       one-cycle strobe for a parity failure
//   busy               high whenever a frame is in progress
// ---------------------------------------------------------------------------
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] last_data_received,
    output logic       key_pressed,
    output logic       frame_error,
    output logic       parity_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int              FW          = $clog2(FILTER_LEN + 1);
    localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0]   FILT_LAST   = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    state_t        state_q, state_d;

    logic          clk_meta, clk_sync;
    logic          dat_meta, dat_sync;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          parity_ok;

    logic          start_frame, shift_en, stop_hit, key_set, ferr_set;

    // -----------------------------------------------------------------------
    // Input synchronizers. These idle high, like an undriven PS/2 bus.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        // NOTE: clocked state always uses non-blocking assignments, so every
        // flop samples the value from before the edge and the order of the
        // statements does not matter.
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Clock glitch filter. filt_cnt counts consecutive samples that differ
    // from the current filtered level. Any sample that agrees with the
    // current level restarts the count.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    // -----------------------------------------------------------------------
    // Inter-edge timeout. A falling edge in the same cycle takes priority,
    // so a timeout can only fire in a cycle that has no edge.
    // -----------------------------------------------------------------------
    assign timeout_hit = (state_q != IDLE) && !fall && (to_cnt == TIMEOUT_MAX);

    always_ff @(posedge CLOCK_50) begin
        if (reset || state_q == IDLE || fall || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall && !dat_sync)          state_d = DATA;
            DATA:    if (fall && bit_cnt == 3'd7)    state_d = PARITY;
            PARITY:  if (fall)                       state_d = STOP;
            STOP:    if (fall)                       state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
        if (timeout_hit) state_d = IDLE;
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // -----------------------------------------------------------------------
    always_comb begin
        busy        = 1'b1;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        stop_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                busy        = 1'b0;
                start_frame = fall && !dat_sync;
            end
            DATA:    shift_en = fall;
            PARITY:  ;
            STOP:    stop_hit = fall;
            default: busy = 1'b0;
        endcase
        // A bad stop bit takes priority over a parity failure.
        key_set  = stop_hit && dat_sync && parity_ok;
        ferr_set = (stop_hit && !dat_sync) || timeout_hit;
    end

    // -----------------------------------------------------------------------
    // Datapath. The strobes are registered, so they appear one cycle after
    // the stop-bit edge is detected, together with the new byte.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt            <= '0;
            shift_q            <= '0;
            last_data_received <= '0;
            key_pressed        <= 1'b0;
            frame_error        <= 1'b0;
        end else begin
            key_pressed <= key_set;
            frame_error <= ferr_set;
            if (start_frame) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (shift_en) begin
                shift_q <= {dat_sync, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (key_set) last_data_received <= shift_q;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic parity_bit;

    // Odd parity: the data byte plus the parity bit hold an odd number of ones.
    assign parity_ok = ^{parity_bit, shift_q};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (state_q == PARITY && fall) parity_bit <= dat_sync;
            parity_error <= stop_hit && dat_sync && !parity_ok;
        end
    end
`else
    assign parity_ok    = 1'b1;
    assign parity_error = 1'b0;
`endif

endmodule
